ppu_readback: RTL

PPU_READBACK -- requirements
Module: ppu_readback

---
 rtl/ppu_readback_if.sv | 20 ++
 rtl/ppu_readback.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ppu_readback_if.sv
// CPU slave bus between the host processor and the PPU readback block.
interface ppu_readback_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [11:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        readdatavalid;

  modport master (
    output chipselect, read, write, address, write_data,
    input  read_data, readdatavalid
  );

  modport slave (
    input  chipselect, read, write, address, write_data,
    output read_data, readdatavalid
  );
endinterface

// File: rtl/ppu_readback.sv
// PPU readback slave: fixed-latency (3 cycle) read pipeline serving either
// local status/control registers (0xFFC-0xFFF) or forwarded memory reads,
// plus vblank edge detection, frame counter and a level interrupt.
module ppu_readback (
  input  logic          clk,
  input  logic          reset,
  ppu_readback_if.slave bus,
  input  logic          vblank,
  input  logic [9:0]    vcount,
  output logic          irq,
  output logic          mem_rd_en,
  output logic [11:0]   mem_rd_addr,
  input  logic [31:0]   mem_rd_data
);

  // Control / status state
  logic        vblank_q;
  logic        armed_q;      // low for the first cycle after reset release
  logic        pending_q, pending_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic        irq_q;

  // Read pipeline: stage 1 (N+1), stage 2 (N+2), output (N+3)
  logic        s1_vld_q, s1_isreg_q;
  logic [31:0] s1_val_q;
  logic        s2_vld_q, s2_isreg_q;
  logic [31:0] s2_val_q;
  logic        rdv_q;
  logic [31:0] rdata_q;
  logic        mem_en_q;
  logic [11:0] mem_addr_q;

  logic        rd_acc, wr_acc, is_reg, vb_rise;
  logic [31:0] reg_val;
  logic        unused_wd;

  // Only bit 0 of write data has meaning in this block.
  assign unused_wd = ^bus.write_data[31:1];

  // Bus decode, register read mux and next-state for the control registers.
  always_comb begin
    rd_acc      = bus.chipselect && bus.read && !bus.write;
    wr_acc      = bus.chipselect && bus.write;
    is_reg      = &bus.address[11:2];
    vb_rise     = vblank && !vblank_q && armed_q;
    reg_val     = '0;
    pending_d   = pending_q;
    irq_en_d    = irq_en_q;
    frame_cnt_d = frame_cnt_q;

    case (bus.address[1:0])
      2'd0:    reg_val = {6'b0, vcount, 14'b0, pending_q, vblank};
      2'd1:    reg_val = {31'b0, irq_en_q};
      2'd2:    reg_val = '0;
      default: reg_val = frame_cnt_q;
    endcase

    if (wr_acc && (bus.address == 12'hFFD))
      irq_en_d = bus.write_data[0];

    // A new vblank edge beats a same-cycle acknowledge.
    if (vb_rise)
      pending_d = 1'b1;
    else if (wr_acc && (bus.address == 12'hFFE) && bus.write_data[0])
      pending_d = 1'b0;

    if (vb_rise)
      frame_cnt_d = frame_cnt_q + 32'd1;
  end

  // Control registers, vblank history and registered interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vblank_q    <= 1'b0;
      armed_q     <= 1'b0;
      pending_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      frame_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      vblank_q    <= vblank;
      armed_q     <= 1'b1;
      pending_q   <= pending_d;
      irq_en_q    <= irq_en_d;
      frame_cnt_q <= frame_cnt_d;
      irq_q       <= pending_q && irq_en_q;
    end
  end

  // Three-stage read pipeline; register values are snapshotted at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q   <= 1'b0;
      s1_isreg_q <= 1'b0;
      s1_val_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_isreg_q <= 1'b0;
      s2_val_q   <= '0;
      rdv_q      <= 1'b0;
      rdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      s1_vld_q   <= rd_acc;
      s1_isreg_q <= is_reg;
      s1_val_q   <= (rd_acc && is_reg) ? reg_val : '0;
      mem_en_q   <= rd_acc && !is_reg;
      if (rd_acc && !is_reg)
        mem_addr_q <= bus.address;
      s2_vld_q   <= s1_vld_q;
      s2_isreg_q <= s1_isreg_q;
      s2_val_q   <= s1_val_q;
      rdv_q      <= s2_vld_q;
      rdata_q    <= s2_vld_q ? (s2_isreg_q ? s2_val_q : mem_rd_data) : '0;
    end
  end

  assign bus.readdatavalid = rdv_q;
  assign bus.read_data     = rdata_q;
  assign mem_rd_en         = mem_en_q;
  assign mem_rd_addr       = mem_addr_q;
  assign irq               = irq_q;

endmodule
